// File: rtl/div_ctrl_fsm.sv
// Purpose: sequencing controller for a restoring shift-subtract divider; drives
//          the remainder register strobes and ALU subtract select, registers the
//          quotient bit and reports sign-fix flags.
// Latency: Start accept to Ready is 3 + 2*WIDTH + 1 cycles (1 cycle for a zero divisor).
// Backpressure: Start is honoured only in IDLE or DONE; it is ignored while Busy.
// Ports:
//   clk, Reset (sync, active-low)       - clock and reset
//   Start, Signed_op, Dividend_sign,
//   Divisor_sign, Divisor_zero           - operation request and operand flags
//   ALU_carry                            - no-borrow flag of (rem upper - divisor)
//   Rem_load, SLL_ctrl, SRL_ctrl, W_ctrl - remainder register strobes (one-hot or idle)
//   Shift_bit                            - quotient bit shifted in on SLL_ctrl
//   ALU_sub                              - ALU subtract select
//   Ready, Busy, Div_by_zero             - status
//   Neg_Quot, Neg_Rem                    - sign-fix flags, valid while Ready
module div_ctrl_fsm #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic clk,
   input  logic Reset,
   input  logic Start,
   input  logic Signed_op,
   input  logic Dividend_sign,
   input  logic Divisor_sign,
   input  logic Divisor_zero,
   input  logic ALU_carry,
   output logic Rem_load,
   output logic SLL_ctrl,
   output logic SRL_ctrl,
   output logic W_ctrl,
   output logic Shift_bit,
   output logic ALU_sub,
   output logic Ready,
   output logic Busy,
   output logic Div_by_zero,
   output logic Neg_Quot,
   output logic Neg_Rem
);

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      LOAD       = 3'd1,
      INIT_SHIFT = 3'd2,
      SUB        = 3'd3,
      SHIFT      = 3'd4,
      FIX        = 3'd5,
      DONE       = 3'd6
   } state_t;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH);

   state_t           r_state;
   state_t           w_next_state;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_inc;
   logic             w_last;
   logic             w_accept;
   logic             r_shift_bit;
   logic             r_signed;
   logic             r_dd_sign;
   logic             r_dv_sign;
   logic             r_dbz;

   assign w_accept  = Start && ((r_state == IDLE) || (r_state == DONE));
   assign w_cnt_inc = r_cnt + 1'b1;
   assign w_last    = (w_cnt_inc == LAST_CNT);

   always_ff @(posedge clk) begin
      if (!Reset) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_shift_bit <= 1'b0;
         r_signed    <= 1'b0;
         r_dd_sign   <= 1'b0;
         r_dv_sign   <= 1'b0;
         r_dbz       <= 1'b0;
      end else begin
         r_state <= w_next_state;

         if (w_accept) begin
            r_signed  <= Signed_op;
            r_dd_sign <= Dividend_sign;
            r_dv_sign <= Divisor_sign;
            r_dbz     <= Divisor_zero;
         end

         if (r_state == LOAD) begin
            r_cnt <= '0;
         end else if ((r_state == SHIFT) && (r_cnt != LAST_CNT)) begin
            r_cnt <= w_cnt_inc;
         end

         // Quotient bit is only meaningful in the SHIFT that follows a SUB;
         // everywhere else it is held at 0, which also gives the 0 inserted
         // by the initial shift.
         r_shift_bit <= (r_state == SUB) ? ALU_carry : 1'b0;
      end
   end

   always_comb begin
      w_next_state = r_state;
      Rem_load     = 1'b0;
      SLL_ctrl     = 1'b0;
      SRL_ctrl     = 1'b0;
      W_ctrl       = 1'b0;
      ALU_sub      = 1'b0;
      Ready        = 1'b0;
      Busy         = 1'b0;
      Neg_Quot     = 1'b0;
      Neg_Rem      = 1'b0;

      case (r_state)
         IDLE: begin
            if (Start) begin
               w_next_state = Divisor_zero ? DONE : LOAD;
            end
         end
         LOAD: begin
            Busy         = 1'b1;
            Rem_load     = 1'b1;
            w_next_state = INIT_SHIFT;
         end
         INIT_SHIFT: begin
            Busy         = 1'b1;
            SLL_ctrl     = 1'b1;
            w_next_state = SUB;
         end
         SUB: begin
            Busy         = 1'b1;
            ALU_sub      = 1'b1;
            // Commit the difference only when it did not borrow (restoring step).
            W_ctrl       = ALU_carry;
            w_next_state = SHIFT;
         end
         SHIFT: begin
            Busy         = 1'b1;
            SLL_ctrl     = 1'b1;
            w_next_state = w_last ? FIX : SUB;
         end
         FIX: begin
            Busy         = 1'b1;
            // The last shift moved the remainder one place too far left.
            SRL_ctrl     = 1'b1;
            w_next_state = DONE;
         end
         DONE: begin
            Ready    = 1'b1;
            Neg_Quot = r_signed & (r_dd_sign ^ r_dv_sign) & ~r_dbz;
            Neg_Rem  = r_signed & r_dd_sign & ~r_dbz;
            if (Start) begin
               w_next_state = Divisor_zero ? DONE : LOAD;
            end
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

   assign Shift_bit   = r_shift_bit;
   assign Div_by_zero = r_dbz;

endmodule

// File: tb/tb_div_ctrl_fsm.sv
// Purpose: directed bench for div_ctrl_fsm with a behavioural remainder register
//          and ALU attached; checks latency, strobe counts, results and flags.
// Ports: none (top-level bench).
module tb_div_ctrl_fsm;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic Reset, Start, Signed_op, Dividend_sign, Divisor_sign, Divisor_zero, ALU_carry;
   logic Rem_load, SLL_ctrl, SRL_ctrl, W_ctrl, Shift_bit, ALU_sub;
   logic Ready, Busy, Div_by_zero, Neg_Quot, Neg_Rem;

   div_ctrl_fsm #(.WIDTH(32), .CNT_W(6)) u_dut (
      .clk          (clk),
      .Reset        (Reset),
      .Start        (Start),
      .Signed_op    (Signed_op),
      .Dividend_sign(Dividend_sign),
      .Divisor_sign (Divisor_sign),
      .Divisor_zero (Divisor_zero),
      .ALU_carry    (ALU_carry),
      .Rem_load     (Rem_load),
      .SLL_ctrl     (SLL_ctrl),
      .SRL_ctrl     (SRL_ctrl),
      .W_ctrl       (W_ctrl),
      .Shift_bit    (Shift_bit),
      .ALU_sub      (ALU_sub),
      .Ready        (Ready),
      .Busy         (Busy),
      .Div_by_zero  (Div_by_zero),
      .Neg_Quot     (Neg_Quot),
      .Neg_Rem      (Neg_Rem)
   );

   // Remainder register + ALU model driven by the DUT strobes.
   logic [63:0] rem = 64'd0;
   logic [31:0] dividend = 32'd0;
   logic [31:0] divisor = 32'd1;
   int          mode = 0;   // 0: real ALU, 1: carry forced 1, 2: carry forced 0

   assign ALU_carry = (mode == 0) ? (rem[63:32] >= divisor) : (mode == 1);

   int n_load = 0, n_sll = 0, n_srl = 0, n_w = 0, n_sub = 0;
   int n_sll1 = 0, n_wbad = 0, n_excl = 0;

   always @(posedge clk) begin
      if (Rem_load)      rem <= {32'd0, dividend};
      else if (W_ctrl)   rem[63:32] <= rem[63:32] - divisor;
      else if (SLL_ctrl) rem <= {rem[62:0], Shift_bit};
      else if (SRL_ctrl) rem[63:32] <= rem[63:32] >> 1;
      n_load <= n_load + int'(Rem_load);
      n_sll  <= n_sll + int'(SLL_ctrl);
      n_srl  <= n_srl + int'(SRL_ctrl);
      n_w    <= n_w + int'(W_ctrl);
      n_sub  <= n_sub + int'(ALU_sub);
      n_sll1 <= n_sll1 + int'(SLL_ctrl && Shift_bit);
      n_wbad <= n_wbad + int'(W_ctrl && !ALU_sub);
      if ((int'(Rem_load) + int'(SLL_ctrl) + int'(SRL_ctrl) + int'(W_ctrl)) > 1)
         n_excl <= n_excl + 1;
   end

   logic [10:0] outs;
   assign outs = {Rem_load, SLL_ctrl, SRL_ctrl, W_ctrl, Shift_bit, ALU_sub,
                  Ready, Busy, Div_by_zero, Neg_Quot, Neg_Rem};

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issues Start for one edge and waits (bounded) for Ready. Optionally pulses
   // Start during cycles 5, 20 and 40 of the run. rdy1 is Ready after the accept edge.
   task automatic run(input bit pulses, output int cyc, output logic rdy1);
      cyc  = 0;
      rdy1 = 1'b0;
      Start = 1'b1;
      do begin
         step();
         cyc++;
         if (cyc == 1) rdy1 = Ready;
         Start = pulses && ((cyc == 4) || (cyc == 19) || (cyc == 39));
      end while (!Ready && (cyc < 200));
      Start = 1'b0;
   endtask

   task automatic set_op(input logic [31:0] dd, input logic [31:0] dv, input logic sgn);
      dividend      = dd;
      divisor       = dv;
      Signed_op     = sgn;
      Dividend_sign = dd[31];
      Divisor_sign  = dv[31];
      Divisor_zero  = (dv == 32'd0);
   endtask

   initial begin
      int   cyc;
      logic rdy1;
      int   s_load, s_sll, s_srl, s_w, s_sub, s_sll1;

      Reset = 1'b0; Start = 1'b0; Signed_op = 1'b0; Dividend_sign = 1'b0;
      Divisor_sign = 1'b0; Divisor_zero = 1'b0;
      step(); step();
      chk("reset_outs", 64'(outs), 64'd0);
      Reset = 1'b1;
      step();

      // Unsigned 100 / 7 with model ALU
      set_op(32'd100, 32'd7, 1'b0);
      s_load = n_load; s_sll = n_sll; s_srl = n_srl;
      run(1'b0, cyc, rdy1);
      chk("udiv_latency", 64'(cyc), 64'd68);
      chk("udiv_sll", 64'(n_sll - s_sll), 64'd33);
      chk("udiv_srl", 64'(n_srl - s_srl), 64'd1);
      chk("udiv_load", 64'(n_load - s_load), 64'd1);
      chk("udiv_rem_hi", 64'(rem[63:32]), 64'd2);
      chk("udiv_rem_lo", 64'(rem[31:0]), 64'd14);
      chk("udiv_busy", 64'(Busy), 64'd0);
      chk("udiv_flags", 64'({Div_by_zero, Neg_Quot, Neg_Rem}), 64'd0);

      // Signed -7 / 2, started back-to-back from the previous DONE
      set_op(32'hFFFF_FFF9, 32'd2, 1'b1);
      run(1'b0, cyc, rdy1);
      chk("b2b_ready_drop", 64'(rdy1), 64'd0);
      chk("b2b_latency", 64'(cyc), 64'd68);
      chk("sdiv_negq", 64'(Neg_Quot), 64'd1);
      chk("sdiv_negr", 64'(Neg_Rem), 64'd1);

      // Divide by zero from DONE: flags cleared, no strobes
      set_op(32'hFFFF_FFF9, 32'd0, 1'b1);
      s_load = n_load; s_sll = n_sll; s_srl = n_srl; s_w = n_w; s_sub = n_sub;
      run(1'b0, cyc, rdy1);
      chk("dbz_latency", 64'(cyc), 64'd1);
      chk("dbz_flag", 64'({Ready, Div_by_zero}), 64'b11);
      chk("dbz_neg", 64'({Neg_Quot, Neg_Rem}), 64'd0);
      repeat (3) step();
      chk("dbz_strobes", 64'((n_load - s_load) + (n_sll - s_sll) + (n_srl - s_srl)
                            + (n_w - s_w) + (n_sub - s_sub)), 64'd0);
      chk("dbz_hold", 64'({Ready, Div_by_zero}), 64'b11);

      // Same operands as -7/2 but unsigned
      set_op(32'hFFFF_FFF9, 32'd2, 1'b0);
      run(1'b0, cyc, rdy1);
      chk("udiv2_neg", 64'({Neg_Quot, Neg_Rem, Div_by_zero}), 64'd0);

      // Signed 7 / -2 with ignored Start pulses while busy
      set_op(32'd7, 32'hFFFF_FFFE, 1'b1);
      run(1'b1, cyc, rdy1);
      chk("busy_start_latency", 64'(cyc), 64'd68);
      chk("s7m2_neg", 64'({Neg_Quot, Neg_Rem}), 64'b10);

      // Forced carry 1: every SUB writes, every SHIFT inserts 1
      set_op(32'd5, 32'd3, 1'b0);
      mode = 1;
      s_w = n_w; s_sll1 = n_sll1;
      run(1'b0, cyc, rdy1);
      chk("c1_w_pulses", 64'(n_w - s_w), 64'd32);
      chk("c1_sll_ones", 64'(n_sll1 - s_sll1), 64'd32);

      // Forced carry 0: no writes, no quotient ones
      mode = 2;
      s_w = n_w; s_sll1 = n_sll1;
      run(1'b0, cyc, rdy1);
      chk("c0_w_pulses", 64'(n_w - s_w), 64'd0);
      chk("c0_sll_ones", 64'(n_sll1 - s_sll1), 64'd0);
      mode = 0;

      // Reset during SUB of iteration 10 (edge 21 after accept)
      set_op(32'd100, 32'd7, 1'b0);
      Start = 1'b1;
      step();
      Start = 1'b0;
      repeat (20) step();
      chk("mid_in_sub", 64'({ALU_sub, Busy}), 64'b11);
      Reset = 1'b0;
      step();
      chk("mid_reset_outs1", 64'(outs), 64'd0);
      step();
      chk("mid_reset_outs2", 64'(outs), 64'd0);
      Reset = 1'b1;
      step();
      chk("post_reset_idle", 64'(outs), 64'd0);
      run(1'b0, cyc, rdy1);
      chk("post_reset_latency", 64'(cyc), 64'd68);
      chk("post_reset_rem", rem, {32'd2, 32'd14});

      chk("strobe_exclusive", 64'(n_excl), 64'd0);
      chk("w_outside_sub", 64'(n_wbad), 64'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/div_ctrl_fsm.md
Name: div_ctrl_fsm

Overview:
Sequencing controller for the shift-subtract (restoring) divider. It drives the remainder register's load, shift-left, shift-right and write strobes, and the ALU subtract select. It registers the quotient bit shifted into the remainder register and produces the sign-fix flags consumed downstream. It sits directly upstream of the remainder register; its strobes are the remainder register's only control inputs.

Parameters:
WIDTH, 32, operand width and number of iterations
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clk  input  1  rising-edge clock
Reset  input  1  synchronous, active-low reset; sampled on posedge clk
Start  input  1  begin a division; accepted only in IDLE or DONE
Signed_op  input  1  1 = signed divide (sign-fix flags valid), 0 = unsigned
Dividend_sign  input  1  MSB of dividend; sampled on Start accept
Divisor_sign  input  1  MSB of divisor; sampled on Start accept
Divisor_zero  input  1  divisor == 0; sampled on Start accept
ALU_carry  input  1  no-borrow flag of (remainder upper half - divisor)
Rem_load  output  1  load remainder with {0, dividend}; drives the remainder register's reset/load input
SLL_ctrl  output  1  shift the remainder left by 1, inserting Shift_bit
SRL_ctrl  output  1  shift the remainder upper half right by 1
W_ctrl  output  1  write the ALU result into the remainder upper half
Shift_bit  output  1  registered quotient bit; the top level feeds it to the remainder register's carry input
ALU_sub  output  1  1 = ALU performs subtract
Ready  output  1  result valid; remainder register must hold
Busy  output  1  operation in progress
Div_by_zero  output  1  last operation had a zero divisor
Neg_Quot  output  1  quotient must be negated (Signed_op & (Dividend_sign ^ Divisor_sign))
Neg_Rem  output  1  remainder must be negated (Signed_op & Dividend_sign)

Behaviour:
- States: IDLE, LOAD, INIT_SHIFT, SUB, SHIFT, FIX, DONE.
- Reset low at a posedge: state to IDLE, counter 0. All outputs 0: Ready, Busy, Shift_bit, Div_by_zero, Neg_Quot, Neg_Rem, and every strobe. This applies mid-operation as well; the partial result is discarded.
- IDLE / DONE, Start=1:
  - Latch Signed_op, both signs and Divisor_zero into internal registers.
  - Clear Ready and Div_by_zero.
  - Go to LOAD, or straight to DONE with Div_by_zero=1 if Divisor_zero=1. A zero divisor produces no strobes.
- Start while Busy: ignored, no effect.
- LOAD (1 cycle): Rem_load=1, counter cleared, next state INIT_SHIFT.
- INIT_SHIFT (1 cycle): SLL_ctrl=1 with Shift_bit=0, next state SUB.
- SUB (1 cycle):
  - ALU_sub=1.
  - W_ctrl = ALU_carry, combinational in the same cycle.
  - Shift_bit is registered with ALU_carry at the cycle end.
  - Next state SHIFT.
- SHIFT (1 cycle):
  - SLL_ctrl=1, inserting the registered Shift_bit.
  - Counter increments.
  - Next state is FIX if the counter reaches WIDTH after the increment; otherwise SUB.
- FIX (1 cycle): SRL_ctrl=1, next state DONE.
- DONE:
  - Ready=1, Busy=0.
  - Neg_Quot and Neg_Rem are driven from the latched values and held until the next Start or Reset.
  - Divide-by-zero: Neg_Quot and Neg_Rem are 0.
- Busy=1 in LOAD, INIT_SHIFT, SUB, SHIFT and FIX; 0 otherwise.
- Mutual exclusion: at most one of Rem_load, SLL_ctrl, SRL_ctrl, W_ctrl is high in any cycle. ALU_sub is high only in SUB.
- Latency: Start accept to first Ready cycle is 3 + 2*WIDTH + 1 cycles, i.e. 68 at WIDTH=32. For divide-by-zero it is 1 cycle.
- Back-to-back: Start asserted in the first DONE cycle restarts immediately. Ready drops on the next edge.
- Counter: never exceeds WIDTH and does not wrap. Unsigned arithmetic of CNT_W bits.

Test Plan:
- Reset low for 2 cycles mid-SUB (iteration 10) -> next cycle state IDLE, all outputs 0; a subsequent Start gives a full 68-cycle run.
- Unsigned 100/7 with the remainder register and ALU attached:
  - Ready on cycle 68 after Start.
  - Exactly 32 SLL pulses after the initial shift, 1 SRL pulse and 1 Rem_load pulse.
  - Remainder upper half = 2, lower half = 14.
- Divisor_zero=1 with Start -> next cycle Ready=1, Div_by_zero=1, no strobes ever asserted.
- Signed -7/2 (Dividend_sign=1, Divisor_sign=0) -> at DONE Neg_Quot=1, Neg_Rem=1. The same operands with Signed_op=0 give Neg_Quot=0, Neg_Rem=0.
- Start pulsed at cycles 5, 20 and 40 of an active run -> ignored; Ready still arrives on cycle 68. Start held in the first DONE cycle restarts with Ready low on the next edge.
- Forced ALU_carry=1 on every SUB -> 32 W_ctrl pulses, each in a SUB cycle, and Shift_bit=1 on every SHIFT. Forced ALU_carry=0 -> 0 W_ctrl pulses.
